credit_fifo_sender: RTL and testbench



---
 rtl/credit_fifo_pkg.sv | 7 +
 rtl/credit_fifo_sender_if.sv | 31 +++
 rtl/credit_fifo_skid_queue.sv | 32 +++
 rtl/credit_fifo_sender.sv | 72 +++++++
 tb/tb_credit_fifo_sender.sv | 146 ++++++++++++++
 5 files changed

// File: rtl/credit_fifo_pkg.sv
// credit_fifo_pkg: shared state encoding and credit counter sizing for credit_fifo_sender
package credit_fifo_pkg;
  typedef enum logic [1:0] {IDLE, SEND, STALL, ERR} state_t;
  function automatic int credit_width(input int max_credits);
    return $clog2(max_credits + 1);
  endfunction
endpackage

// File: rtl/credit_fifo_sender_if.sv
// credit_fifo_sender_if: local valid/ready input, FIFO write port and credit return
//   master (sender): in_data/in_valid/wcredit in; in_ready/wdata/wvalid/credits/credit_err out
//   slave: the mirror view used by local logic and the FIFO side
//   CREDIT_FIFO_SENDER_STATS_EN adds sent_count and stall_cycles
interface credit_fifo_sender_if import credit_fifo_pkg::*; #(
  parameter int DATA_WIDTH  = 8,
  parameter int MAX_CREDITS = 16,
  parameter int CW          = credit_width(MAX_CREDITS)
);
  logic [DATA_WIDTH-1:0] in_data;
  logic                  in_valid;
  logic                  in_ready;
  logic [DATA_WIDTH-1:0] wdata;
  logic                  wvalid;
  logic                  wcredit;
  logic [CW-1:0]         credits;
  logic                  credit_err;
`ifdef CREDIT_FIFO_SENDER_STATS_EN
  logic [31:0]           sent_count;
  logic [31:0]           stall_cycles;
  modport master(input in_data, in_valid, wcredit,
                 output in_ready, wdata, wvalid, credits, credit_err, sent_count, stall_cycles);
  modport slave(output in_data, in_valid, wcredit,
                input in_ready, wdata, wvalid, credits, credit_err, sent_count, stall_cycles);
`else
  modport master(input in_data, in_valid, wcredit,
                 output in_ready, wdata, wvalid, credits, credit_err);
  modport slave(output in_data, in_valid, wcredit,
                input in_ready, wdata, wvalid, credits, credit_err);
`endif
endinterface

// File: rtl/credit_fifo_skid_queue.sv
// credit_fifo_skid_queue: 2-entry FIFO-order word buffer
//   i_push/i_data write a word, i_pop drops the head, o_head is the oldest word, o_count 0..2
module credit_fifo_skid_queue #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  i_push,
  input  logic [DATA_WIDTH-1:0] i_data,
  input  logic                  i_pop,
  output logic [DATA_WIDTH-1:0] o_head,
  output logic [1:0]            o_count
);
  logic [DATA_WIDTH-1:0] r_mem [2];
  logic                  r_rd;
  logic                  r_wr;
  logic [1:0]            r_cnt;
  always_ff @(posedge clk)
    if (i_push) r_mem[r_wr] <= i_data;
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      r_rd  <= 1'b0;
      r_wr  <= 1'b0;
      r_cnt <= 2'd0;
    end else begin
      if (i_push) r_wr <= !r_wr;
      if (i_pop) r_rd <= !r_rd;
      r_cnt <= r_cnt + 2'(i_push) - 2'(i_pop);
    end
  assign o_head  = r_mem[r_rd];
  assign o_count = r_cnt;
endmodule

// File: rtl/credit_fifo_sender.sv
// credit_fifo_sender: credit-gated transmitter feeding a FIFO write port from a 2-entry skid queue
//   clk/reset (async, active-high); bus: credit_fifo_sender_if master modport
//   CREDIT_FIFO_SENDER_STATS_EN adds 32-bit wrapping sent_count and stall_cycles
module credit_fifo_sender import credit_fifo_pkg::*; #(
  parameter int DATA_WIDTH   = 8,
  parameter int INIT_CREDITS = 16,
  parameter int MAX_CREDITS  = 16
) (
  input logic                  clk,
  input logic                  reset,
  credit_fifo_sender_if.master bus
);
  localparam int CW = credit_width(MAX_CREDITS);
  state_t                r_state;
  logic [CW-1:0]         r_credits;
  logic                  r_wvalid;
  logic [DATA_WIDTH-1:0] r_wdata;
  logic                  r_err;
  logic [DATA_WIDTH-1:0] w_head;
  logic [1:0]            w_cnt;
  logic [1:0]            w_cnt_next;
  logic                  w_push;
  logic                  w_send;
  logic                  w_ovf;
  logic [CW:0]           w_credits_next;
  credit_fifo_skid_queue #(.DATA_WIDTH(DATA_WIDTH)) u_queue (
    .clk(clk), .reset(reset), .i_push(w_push), .i_data(bus.in_data),
    .i_pop(w_send), .o_head(w_head), .o_count(w_cnt)
  );
  // fullness is taken before any pop, so a full queue refuses input even while draining
  assign bus.in_ready   = w_cnt != 2'd2 && r_state != ERR;
  assign w_push         = bus.in_valid && bus.in_ready;
  assign w_send         = w_cnt != 2'd0 && r_credits != '0 && r_state != ERR;
  // one extra bit so a return at MAX_CREDITS is visible as overflow
  assign w_credits_next = {1'b0, r_credits} - (CW+1)'(w_send) + (CW+1)'(bus.wcredit);
  assign w_ovf          = r_state != ERR && w_credits_next > (CW+1)'(MAX_CREDITS);
  assign w_cnt_next     = w_cnt + 2'(w_push) - 2'(w_send);
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      r_state   <= IDLE;
      r_credits <= CW'(INIT_CREDITS);
      r_wvalid  <= 1'b0;
      r_wdata   <= '0;
      r_err     <= 1'b0;
    end else begin
      r_wvalid <= w_send;
      if (w_send) r_wdata <= w_head;
      r_err <= r_err | w_ovf;
      if (r_state != ERR) r_credits <= w_ovf ? CW'(MAX_CREDITS) : w_credits_next[CW-1:0];
      r_state <= (r_state == ERR || w_ovf) ? ERR :
                 w_cnt_next == 2'd0        ? IDLE :
                 w_credits_next != '0      ? SEND : STALL;
    end
  assign bus.wvalid     = r_wvalid;
  assign bus.wdata      = r_wdata;
  assign bus.credits    = r_credits;
  assign bus.credit_err = r_err;
`ifdef CREDIT_FIFO_SENDER_STATS_EN
  logic [31:0] r_sent_count;
  logic [31:0] r_stall_cycles;
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      r_sent_count   <= '0;
      r_stall_cycles <= '0;
    end else begin
      r_sent_count   <= r_sent_count + 32'(w_send);
      r_stall_cycles <= r_stall_cycles + 32'(r_state == STALL);
    end
  assign bus.sent_count   = r_sent_count;
  assign bus.stall_cycles = r_stall_cycles;
`endif
endmodule

// File: tb/tb_credit_fifo_sender.sv
// tb_credit_fifo_sender: randomized and directed stimulus against a queue-based credit model
module tb_credit_fifo_sender;
  import credit_fifo_pkg::*;
  localparam int DW   = 8;
  localparam int MAXC = 16;
  logic clk = 1'b0;
  logic reset = 1'b1;
  credit_fifo_sender_if #(.DATA_WIDTH(DW), .MAX_CREDITS(MAXC)) bus();
  credit_fifo_sender #(.DATA_WIDTH(DW), .INIT_CREDITS(16), .MAX_CREDITS(MAXC)) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );
  always #5 clk = ~clk;
  int n_cmp = 0;
  int n_bad = 0;
  byte unsigned m_q[$];
  int   m_cred;
  bit   m_err;
  bit   m_wv;
  logic [7:0] m_wd;
  int   m_sent;
  int   m_stall;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic model_reset();
    m_q.delete();
    m_cred  = 16;
    m_err   = 1'b0;
    m_wv    = 1'b0;
    m_wd    = '0;
    m_sent  = 0;
    m_stall = 0;
  endtask
  task automatic check_outputs(input string tag);
    check({tag, "_in_ready"}, 32'(bus.in_ready), 32'(m_q.size() < 2 && !m_err));
    check({tag, "_credits"}, 32'(bus.credits), 32'(m_cred));
    check({tag, "_credit_err"}, 32'(bus.credit_err), 32'(m_err));
    check({tag, "_wvalid"}, 32'(bus.wvalid), 32'(m_wv));
    if (m_wv) check({tag, "_wdata"}, 32'(bus.wdata), 32'(m_wd));
`ifdef CREDIT_FIFO_SENDER_STATS_EN
    check({tag, "_sent_count"}, bus.sent_count, 32'(m_sent));
    check({tag, "_stall_cycles"}, bus.stall_cycles, 32'(m_stall));
`endif
  endtask
  // one clock: drive at negedge, advance the model across the posedge, compare at the next negedge
  task automatic cycle(input string tag, input bit v, input logic [7:0] d, input bit c);
    bit rdy, snd;
    bus.in_valid = v;
    bus.in_data  = d;
    bus.wcredit  = c;
    rdy = m_q.size() < 2 && !m_err;
    snd = m_q.size() > 0 && m_cred > 0 && !m_err;
    @(posedge clk);
    if (m_q.size() > 0 && m_cred == 0 && !m_err) m_stall++;
    m_wv = snd;
    if (snd) begin
      m_wd = m_q.pop_front();
      m_sent++;
    end
    if (v && rdy) m_q.push_back(d);
    if (!m_err) begin
      m_cred = m_cred - int'(snd) + int'(c);
      if (m_cred > MAXC) begin
        m_err  = 1'b1;
        m_cred = MAXC;
      end
    end
    @(negedge clk);
    check_outputs(tag);
  endtask
  task automatic idle(input string tag, input int n);
    for (int i = 0; i < n; i++) cycle(tag, 1'b0, 8'h00, 1'b0);
  endtask
  // reset lands between edges; wvalid must fall without waiting for a clock
  task automatic pulse_reset(input string tag);
    bus.in_valid = 1'b0;
    bus.wcredit  = 1'b0;
    #2 reset = 1'b1;
    #1;
    model_reset();
    check({tag, "_async_wvalid"}, 32'(bus.wvalid), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    check_outputs(tag);
  endtask
  initial begin
    int n;
    bus.in_valid = 1'b0;
    bus.in_data  = '0;
    bus.wcredit  = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    check_outputs("rst");
    reset = 1'b0;
    cycle("t1", 1'b1, 8'hA1, 1'b0);
    cycle("t1", 1'b1, 8'hA2, 1'b0);
    cycle("t1", 1'b1, 8'hA3, 1'b0);
    idle("t1", 3);
    check("t1_credits_13", 32'(bus.credits), 32'd13);
    for (int i = 0; i < 15; i++) cycle("t2", 1'b1, 8'($urandom), 1'b0);
    idle("t2", 4);
    check("t2_credits_0", 32'(bus.credits), 32'd0);
    check("t2_full", 32'(bus.in_ready), 32'd0);
    cycle("t2", 1'b0, 8'h00, 1'b1);
    check("t2_no_same_cycle", 32'(bus.wvalid), 32'd0);
    n = 0;
    for (int i = 0; i < 4; i++) begin
      idle("t2", 1);
      n += int'(bus.wvalid);
    end
    check("t2_one_sent", 32'(n), 32'd1);
    for (int i = 0; i < 2; i++) cycle("t3", 1'b1, 8'($urandom), 1'b1);
    n = 0;
    for (int i = 0; i < 16; i++) begin
      cycle("t3", 1'b1, 8'($urandom), 1'b1);
      n += int'(bus.wvalid);
    end
    check("t3_throughput", 32'(n), 32'd16);
    check("t3_credits_const", 32'(bus.credits), 32'd1);
    for (int i = 0; i < 400; i++)
      cycle("rnd", $urandom_range(0, 3) != 0, 8'($urandom),
            m_cred < MAXC && $urandom_range(0, 99) < (i < 200 ? 60 : 15));
    pulse_reset("r0");
    for (int i = 0; i < 11; i++) cycle("r0", 1'b1, 8'($urandom), 1'b0);
    idle("r0", 3);
    cycle("r1", 1'b1, 8'h5A, 1'b0);
    cycle("r1", 1'b1, 8'hC3, 1'b0);
    check("r1_credits_before", 32'(bus.credits), 32'd4);
    pulse_reset("r1");
    idle("r1", 4);
    check("r1_ready_after", 32'(bus.in_ready), 32'd1);
    cycle("ovf", 1'b0, 8'h00, 1'b1);
    check("ovf_err", 32'(bus.credit_err), 32'd1);
    for (int i = 0; i < 6; i++) cycle("ovf", 1'b1, 8'($urandom), 1'($urandom_range(0, 1)));
    check("ovf_ready_low", 32'(bus.in_ready), 32'd0);
    pulse_reset("r2");
    for (int i = 0; i < 40; i++)
      cycle("end", $urandom_range(0, 1) == 1, 8'($urandom), m_cred < MAXC && $urandom_range(0, 1) == 1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
